pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write enables of the PC, IF/ID and ID/EX registers, and the two ID/EX control-zero inputs (bubble, flush).
- Detects load-use hazards, freezes the pipe during multi-cycle memory accesses, flushes on EX-stage redirects, and parks the pipe after HALT retires.
- Keeps saturating stall and flush counters and a sticky memory-timeout error.

Parameters:
MEM_TIMEOUT, 255, max consecutive memBusy cycles before errTimeout sets (8-bit counter)
CNT_WIDTH, 16, width of stallCount and flushCount

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
idRs  input  3  ID-stage source register Rs
idRt  input  3  ID-stage source register Rt
idRsValid  input  1  ID instruction reads Rs
idRtValid  input  1  ID instruction reads Rt
exWriteReg  input  3  ID/EX destination register
exWriteRegValid  input  1  ID/EX destination is valid
exRegWrite  input  1  ID/EX RegWrite
exMemRead  input  1  ID/EX MemRead (load in EX)
exRedirect  input  1  taken branch or jump resolved in EX this cycle
memBusy  input  1  instruction or data memory not ready this cycle
wbHalt  input  1  HALT in MEM/WB
writePc  output  1  PC write enable
writeIfId  output  1  IF/ID write enable
writeIdEx  output  1  ID/EX write enable
writeLate  output  1  EX/MEM and MEM/WB write enable
controlZeroIdEx1  output  1  insert bubble into ID/EX (load-use)
controlZeroIdEx2  output  1  squash ID/EX (redirect)
flushIfId  output  1  squash IF/ID contents to NOP
halted  output  1  pipeline parked
stallCount  output  CNT_WIDTH  cycles with writePc=0 while not HALTED, saturating
flushCount  output  CNT_WIDTH  redirect flushes applied, saturating
errTimeout  output  1  sticky memory-timeout error

Behaviour:
- States: RUN, MEM_WAIT, HALTED.
- Outputs are Mealy: combinational from state and inputs. State, pending flag and counters update on the rising edge of clk.
- Reset (rst=0, asynchronous):
  - State goes to RUN; pendRedirect, counters and errTimeout clear.
  - While rst=0, all write enables, zero and flush outputs, and halted are 0.
- loadUse = exMemRead & exRegWrite & exWriteRegValid & ((idRsValid & idRs==exWriteReg) | (idRtValid & idRt==exWriteReg)).
- Priority within a cycle: wbHalt > memBusy > redirect (exRedirect | pendRedirect) > loadUse > normal.
- RUN, normal: writePc, writeIfId, writeIdEx and writeLate are 1; controlZero and flush outputs are 0.
- RUN, loadUse without redirect:
  - writePc=0, writeIfId=0, writeIdEx=1, controlZeroIdEx1=1, writeLate=1.
  - Exactly one bubble per hazard; the next cycle re-evaluates (forwarding covers EX/MEM).
- RUN, redirect:
  - writePc=1 (target loads), writeIfId=1, flushIfId=1, writeIdEx=1, controlZeroIdEx2=1, writeLate=1.
  - loadUse is ignored in this cycle.
  - flushCount increments; pendRedirect clears.
- memBusy=1 in RUN or MEM_WAIT:
  - All write enables are 0; zero and flush outputs are 0.
  - State goes to MEM_WAIT and the timeout counter increments.
  - If exRedirect=1 in this cycle, pendRedirect sets.
- MEM_WAIT with memBusy=0:
  - Outputs are evaluated as in RUN, with pendRedirect applied; state returns to RUN the same cycle.
  - The timeout counter clears.
- Timeout: counter reaching MEM_TIMEOUT sets errTimeout. It stays set until reset; the pipe keeps waiting.
- wbHalt=1 (any state): writeLate=0, all other write enables 0. State goes to HALTED next edge.
- HALTED:
  - halted=1; all write enables 0; no counter changes.
  - Leaves only on reset; wbHalt and memBusy are ignored.
- stallCount increments on every cycle with writePc=0 in RUN or MEM_WAIT. Both counters saturate at all-ones; they do not wrap.
- Registers with no valid bit (valid=0) never match, including register 0.

Test Plan:
- Reset mid-stall: drive memBusy=1 for 3 cycles, then rst=0 -> all outputs 0 immediately (asynchronous). After rst=1 -> state RUN, stallCount=0.
- Load-use: exMemRead=1, exRegWrite=1, exWriteReg=3, idRs=3, idRsValid=1 -> one cycle with writePc=0, writeIfId=0, controlZeroIdEx1=1; stallCount=1. With idRsValid=0 -> no stall.
- Redirect plus load-use in the same cycle -> flushIfId=1, controlZeroIdEx2=1, controlZeroIdEx1=0, writePc=1; flushCount=1.
- exRedirect pulse while memBusy=1, memBusy held 4 cycles -> all enables 0 for 4 cycles. On the first cycle with memBusy=0 -> flushIfId=1 and controlZeroIdEx2=1; stallCount=4.
- memBusy held 300 cycles -> errTimeout rises after cycle 255 and stays 1 after memBusy drops; stallCount=300.
- wbHalt=1 -> next cycle halted=1 and all enables 0. Later exRedirect=1 and memBusy=1 -> no change. stallCount held.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Decides, every
// cycle, which pipeline registers may load and whether ID/EX receives a
// bubble or a squash. Handles load-use hazards, multi-cycle memory waits,
// EX-stage redirects (including redirects that arrive while memory is
// busy), and parking the pipe once HALT reaches write-back.

module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           idRs,
   input  logic [2:0]           idRt,
   input  logic                 idRsValid,
   input  logic                 idRtValid,
   input  logic [2:0]           exWriteReg,
   input  logic                 exWriteRegValid,
   input  logic                 exRegWrite,
   input  logic                 exMemRead,
   input  logic                 exRedirect,
   input  logic                 memBusy,
   input  logic                 wbHalt,
   output logic                 writePc,
   output logic                 writeIfId,
   output logic                 writeIdEx,
   output logic                 writeLate,
   output logic                 controlZeroIdEx1,
   output logic                 controlZeroIdEx2,
   output logic                 flushIfId,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] stallCount,
   output logic [CNT_WIDTH-1:0] flushCount,
   output logic                 errTimeout
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALTED   = 2'd2
   } state_t;

   localparam logic [8:0]           TMO_LIMIT = 9'(MEM_TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   state_t     state;
   logic       pend_redirect;
   logic [7:0] tmo_cnt;
   logic [8:0] tmo_next;
   logic       rs_hit;
   logic       rt_hit;
   logic       load_use;
   logic       redirect;

   // A source register only matches when both sides carry a valid bit, so
   // an unused register field (even r0) can never create a false hazard.
   always_comb begin
      rs_hit   = idRsValid & (idRs == exWriteReg);
      rt_hit   = idRtValid & (idRt == exWriteReg);
      load_use = exMemRead & exRegWrite & exWriteRegValid & (rs_hit | rt_hit);
      redirect = exRedirect | pend_redirect;
      tmo_next = {1'b0, tmo_cnt} + 9'd1;
   end

   // Mealy control outputs, resolved by priority:
   // reset > parked > halt in WB > memory busy > redirect > load-use > normal.
   always_comb begin
      writePc          = 1'b0;
      writeIfId        = 1'b0;
      writeIdEx        = 1'b0;
      writeLate        = 1'b0;
      controlZeroIdEx1 = 1'b0;
      controlZeroIdEx2 = 1'b0;
      flushIfId        = 1'b0;
      halted           = 1'b0;
      if (!rst) begin
         halted = 1'b0;
      end else if (state == HALTED) begin
         halted = 1'b1;
      end else if (wbHalt || memBusy) begin
         halted = 1'b0;
      end else if (redirect) begin
         writePc          = 1'b1;
         writeIfId        = 1'b1;
         writeIdEx        = 1'b1;
         writeLate        = 1'b1;
         flushIfId        = 1'b1;
         controlZeroIdEx2 = 1'b1;
      end else if (load_use) begin
         writeIdEx        = 1'b1;
         writeLate        = 1'b1;
         controlZeroIdEx1 = 1'b1;
      end else begin
         writePc   = 1'b1;
         writeIfId = 1'b1;
         writeIdEx = 1'b1;
         writeLate = 1'b1;
      end
   end

   // State, deferred redirect, timeout tracking and saturating statistics.
   // A redirect seen while memory is busy cannot be applied (nothing may
   // load), so it is remembered and applied on the first ready cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= RUN;
         pend_redirect <= 1'b0;
         tmo_cnt       <= 8'd0;
         errTimeout    <= 1'b0;
         stallCount    <= '0;
         flushCount    <= '0;
      end else begin
         case (state)
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               if (!writePc && stallCount != CNT_MAX) begin
                  stallCount <= stallCount + 1'b1;
               end
               if (wbHalt) begin
                  state <= HALTED;
               end else if (memBusy) begin
                  state <= MEM_WAIT;
                  if (!tmo_next[8]) begin
                     tmo_cnt <= tmo_next[7:0];
                  end
                  if (tmo_next >= TMO_LIMIT) begin
                     errTimeout <= 1'b1;
                  end
                  if (exRedirect) begin
                     pend_redirect <= 1'b1;
                  end
               end else begin
                  state   <= RUN;
                  tmo_cnt <= 8'd0;
                  if (redirect) begin
                     pend_redirect <= 1'b0;
                     if (flushCount != CNT_MAX) begin
                        flushCount <= flushCount + 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed scenarios plus a randomized run, all checked against a
// behavioural model that tracks only "parked", "redirect owed", counter
// values and the length of the current memory wait.

module tb_pipe_hazard_ctrl;

   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [2:0]    idRs, idRt, exWriteReg;
   logic          idRsValid, idRtValid, exWriteRegValid, exRegWrite, exMemRead;
   logic          exRedirect, memBusy, wbHalt;
   logic          writePc, writeIfId, writeIdEx, writeLate;
   logic          controlZeroIdEx1, controlZeroIdEx2, flushIfId, halted;
   logic [CW-1:0] stallCount, flushCount;
   logic          errTimeout;
   logic [7:0]    outs;

   int checks   = 0;
   int failures = 0;

   bit m_halted, m_pend, m_err;
   int m_stall, m_flush, m_busy_run;

   always #5 clk = ~clk;

   assign outs = {writePc, writeIfId, writeIdEx, writeLate,
                  controlZeroIdEx1, controlZeroIdEx2, flushIfId, halted};

   pipe_hazard_ctrl #(.MEM_TIMEOUT(255), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .idRs(idRs), .idRt(idRt), .idRsValid(idRsValid), .idRtValid(idRtValid),
      .exWriteReg(exWriteReg), .exWriteRegValid(exWriteRegValid),
      .exRegWrite(exRegWrite), .exMemRead(exMemRead),
      .exRedirect(exRedirect), .memBusy(memBusy), .wbHalt(wbHalt),
      .writePc(writePc), .writeIfId(writeIfId), .writeIdEx(writeIdEx),
      .writeLate(writeLate), .controlZeroIdEx1(controlZeroIdEx1),
      .controlZeroIdEx2(controlZeroIdEx2), .flushIfId(flushIfId),
      .halted(halted), .stallCount(stallCount), .flushCount(flushCount),
      .errTimeout(errTimeout)
   );

   // Expected output vector {pc,ifid,idex,late,cz1,cz2,flush,halted}.
   function automatic logic [7:0] model_outs();
      bit lu;
      if (!rst) return 8'b0000_0000;
      if (m_halted) return 8'b0000_0001;
      if (wbHalt || memBusy) return 8'b0000_0000;
      if (exRedirect || m_pend) return 8'b1111_0110;
      lu = exMemRead && exRegWrite && exWriteRegValid &&
           ((idRsValid && idRs == exWriteReg) || (idRtValid && idRt == exWriteReg));
      if (lu) return 8'b0011_1000;
      return 8'b1111_0000;
   endfunction

   task automatic model_reset();
      m_halted = 0; m_pend = 0; m_err = 0;
      m_stall = 0; m_flush = 0; m_busy_run = 0;
   endtask

   task automatic model_commit();
      logic [7:0] e;
      e = model_outs();
      if (!rst || m_halted) return;
      if (!e[7] && m_stall < 65535) m_stall++;
      if (wbHalt) begin
         m_halted = 1;
      end else if (memBusy) begin
         m_busy_run++;
         if (m_busy_run >= 255) m_err = 1;
         if (exRedirect) m_pend = 1;
      end else begin
         m_busy_run = 0;
         if (exRedirect || m_pend) begin
            if (m_flush < 65535) m_flush++;
            m_pend = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic clear_inputs();
      idRs = 0; idRt = 0; exWriteReg = 0;
      idRsValid = 0; idRtValid = 0; exWriteRegValid = 0;
      exRegWrite = 0; exMemRead = 0; exRedirect = 0; memBusy = 0; wbHalt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (outs !== 8'b1111_0000)
         $display("[TB] FAIL reset_idle_outs: got %b expected %b", outs, 8'b1111_0000);
      checks++;
      if (stallCount !== 0 || flushCount !== 0 || errTimeout !== 1'b0)
         $display("[TB] FAIL reset_counters: got stall=%0d flush=%0d err=%b expected 0 0 0",
                  stallCount, flushCount, errTimeout);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         memBusy = 1'b1;
         #1;
         checks++;
         if (outs !== model_outs()) begin
            failures++;
            $display("[TB] FAIL reset_busy_outs: got %b expected %b", outs, model_outs());
         end
         tick();
      end
      checks++;
      if (stallCount !== 16'd3) begin
         failures++;
         $display("[TB] FAIL reset_busy_stall: got %0d expected 3", stallCount);
      end
      @(negedge clk);
      memBusy = 1'b0;
      #1;
      checks++;
      if (outs !== 8'b1111_0000) begin
         failures++;
         $display("[TB] FAIL resume_outs: got %b expected %b", outs, 8'b1111_0000);
      end
      #1;
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (outs !== 8'b0000_0000) begin
         failures++;
         $display("[TB] FAIL async_reset_outs: got %b expected 00000000", outs);
      end
      checks++;
      if (stallCount !== 0) begin
         failures++;
         $display("[TB] FAIL async_reset_stall: got %0d expected 0", stallCount);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (outs !== 8'b1111_0000 || stallCount !== 0) begin
         failures++;
         $display("[TB] FAIL post_reset_run: got outs=%b stall=%0d expected 11110000 0",
                  outs, stallCount);
      end
   endtask

   task automatic test_load_use();
      logic [3:0] rs_v, rt_v;
      logic [2:0] rs_r, rt_r;
      do_reset();
      @(negedge clk);
      exMemRead = 1; exRegWrite = 1; exWriteRegValid = 1; exWriteReg = 3;
      idRs = 3; idRsValid = 1;
      #1;
      checks++;
      if (outs !== 8'b0011_1000) begin
         failures++;
         $display("[TB] FAIL load_use_outs: got %b expected 00111000", outs);
      end
      tick();
      checks++;
      if (stallCount !== 16'd1) begin
         failures++;
         $display("[TB] FAIL load_use_stall: got %0d expected 1", stallCount);
      end
      // Rs/Rt valid and register combinations, including r0 with no valid bits
      rs_v = 4'b0101; rt_v = 4'b0011;
      rs_r = 3'd3;    rt_r = 3'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         idRsValid = rs_v[i]; idRtValid = rt_v[i];
         idRs = (i == 3) ? 3'd0 : rs_r;
         idRt = (i == 1) ? 3'd3 : rt_r;
         exWriteReg = (i == 3) ? 3'd0 : 3'd3;
         exWriteRegValid = (i != 3);
         #1;
         checks++;
         if (outs !== model_outs()) begin
            failures++;
            $display("[TB] FAIL load_use_case%0d: got %b expected %b", i, outs, model_outs());
         end
         tick();
         checks++;
         if (stallCount !== 16'(m_stall)) begin
            failures++;
            $display("[TB] FAIL load_use_count%0d: got %0d expected %0d", i, stallCount, m_stall);
         end
      end
   endtask

   task automatic test_redirect_load_use();
      do_reset();
      @(negedge clk);
      exMemRead = 1; exRegWrite = 1; exWriteRegValid = 1; exWriteReg = 5;
      idRt = 5; idRtValid = 1; exRedirect = 1;
      #1;
      checks++;
      if (outs !== 8'b1111_0110) begin
         failures++;
         $display("[TB] FAIL redirect_over_load_use: got %b expected 11110110", outs);
      end
      tick();
      checks++;
      if (flushCount !== 16'd1 || stallCount !== 16'd0) begin
         failures++;
         $display("[TB] FAIL redirect_counts: got flush=%0d stall=%0d expected 1 0",
                  flushCount, stallCount);
      end
   endtask

   task automatic test_busy_redirect();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         memBusy = 1; exRedirect = (i == 0);
         #1;
         checks++;
         if (outs !== 8'b0000_0000) begin
            failures++;
            $display("[TB] FAIL busy_outs%0d: got %b expected 00000000", i, outs);
         end
         tick();
      end
      @(negedge clk);
      memBusy = 0; exRedirect = 0;
      #1;
      checks++;
      if (outs !== 8'b1111_0110) begin
         failures++;
         $display("[TB] FAIL pending_redirect_outs: got %b expected 11110110", outs);
      end
      tick();
      checks++;
      if (stallCount !== 16'd4 || flushCount !== 16'd1) begin
         failures++;
         $display("[TB] FAIL busy_counts: got stall=%0d flush=%0d expected 4 1",
                  stallCount, flushCount);
      end
      @(negedge clk);
      #1;
      checks++;
      if (outs !== 8'b1111_0000) begin
         failures++;
         $display("[TB] FAIL pending_cleared: got %b expected 11110000", outs);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         memBusy = 1;
         #1;
         tick();
         if (i == 254 || i == 255 || i == 300) begin
            checks++;
            if (errTimeout !== (i >= 255)) begin
               failures++;
               $display("[TB] FAIL timeout_at_%0d: got %b expected %b", i, errTimeout, i >= 255);
            end
         end
      end
      @(negedge clk);
      memBusy = 0;
      #1;
      tick();
      checks++;
      if (errTimeout !== 1'b1 || stallCount !== 16'd300) begin
         failures++;
         $display("[TB] FAIL timeout_sticky: got err=%b stall=%0d expected 1 300",
                  errTimeout, stallCount);
      end
   endtask

   task automatic test_halt();
      do_reset();
      @(negedge clk);
      wbHalt = 1;
      #1;
      checks++;
      if (outs !== 8'b0000_0000) begin
         failures++;
         $display("[TB] FAIL halt_cycle_outs: got %b expected 00000000", outs);
      end
      tick();
      checks++;
      if (outs !== 8'b0000_0001 || stallCount !== 16'd1) begin
         failures++;
         $display("[TB] FAIL halted_entry: got outs=%b stall=%0d expected 00000001 1",
                  outs, stallCount);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         wbHalt = 0; exRedirect = 1; memBusy = 1;
         exMemRead = 1; exRegWrite = 1; exWriteRegValid = 1; idRsValid = 1;
         #1;
         tick();
         checks++;
         if (outs !== 8'b0000_0001 || stallCount !== 16'd1 || flushCount !== 16'd0) begin
            failures++;
            $display("[TB] FAIL halted_hold%0d: got outs=%b stall=%0d flush=%0d expected 00000001 1 0",
                     i, outs, stallCount, flushCount);
         end
      end
   endtask

   task automatic test_random();
      int park_cycles;
      park_cycles = 0;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         idRs = 3'($urandom_range(0, 3));
         idRt = 3'($urandom_range(0, 3));
         exWriteReg = 3'($urandom_range(0, 3));
         idRsValid = 1'($urandom);
         idRtValid = 1'($urandom);
         exWriteRegValid = ($urandom_range(0, 3) != 0);
         exRegWrite = ($urandom_range(0, 3) != 0);
         exMemRead = 1'($urandom);
         exRedirect = ($urandom_range(0, 5) == 0);
         memBusy = ($urandom_range(0, 9) < 3);
         wbHalt = ($urandom_range(0, 99) == 0);
         #1;
         checks++;
         if (outs !== model_outs()) begin
            failures++;
            $display("[TB] FAIL random_outs@%0d: got %b expected %b", i, outs, model_outs());
         end
         tick();
         checks++;
         if (stallCount !== 16'(m_stall) || flushCount !== 16'(m_flush) || errTimeout !== m_err) begin
            failures++;
            $display("[TB] FAIL random_counts@%0d: got stall=%0d flush=%0d err=%b expected %0d %0d %b",
                     i, stallCount, flushCount, errTimeout, m_stall, m_flush, m_err);
         end
         if (m_halted) park_cycles++;
         if (park_cycles > 3) begin
            park_cycles = 0;
            do_reset();
         end
      end
   endtask

   // Directed scenarios first, then the randomized run.
   initial begin
      clear_inputs();
      model_reset();
      test_reset();
      test_load_use();
      test_redirect_load_use();
      test_busy_redirect();
      test_timeout();
      test_halt();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
